vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter PIPE_DELAY, 2, number of vga_clk cycles that hs/vs are delayed to line up with the downstream ROM+palette+output-register pixel path.
REQ-002 Parameter ANIM_DIV, 8, number of frames per sprite-animation step.
REQ-003 vga_clk  input  1  pixel clock (25 MHz nominal); sole clock of the block.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 anim_en  input  1  high = animation step counter runs; low = it holds.
REQ-006 DrawX  output  10  current pixel column, 0..799.
REQ-007 DrawY  output  10  current pixel row, 0..524.
REQ-008 blank  output  1  high = visible pixel (DrawX<640 and DrawY<480); consumers draw only when high.
REQ-009 hs  output  1  horizontal sync, active-low, delayed PIPE_DELAY cycles.
REQ-010 vs  output  1  vertical sync, active-low, delayed PIPE_DELAY cycles.
REQ-011 frame_start  output  1  single-cycle pulse marking the start of each new frame.
REQ-012 anim_frame  output  2  sprite animation index for walk-cycle sprite selection.

Function
REQ-013 The horizontal counter shall increment every vga_clk cycle, 0..799, and wrap from 799 to 0.
REQ-014 The vertical counter shall increment only when the horizontal counter wraps, 0..524, and wrap from 524 to 0 on the same cycle the horizontal counter wraps from 799.
REQ-015 DrawX/DrawY shall be the registered counter values, with no added latency.
REQ-016 blank shall be a combinational decode of the current counters: high iff DrawX<640 and DrawY<480.
REQ-017 The raw horizontal sync shall be low iff 656<=DrawX<=751 (96 cycles per line).
REQ-018 The raw vertical sync shall be low iff 490<=DrawY<=491 (2 lines per frame).
REQ-019 hs/vs shall equal raw sync delayed by exactly PIPE_DELAY cycles; PIPE_DELAY=0 shall give undelayed combinational outputs.
REQ-020 frame_start shall be high for exactly the one cycle in which DrawX=0 and DrawY=0 following a wrap from (799,524).
REQ-021 frame_start shall not be asserted in the first (0,0) period after reset release.
REQ-022 Line period shall be 800 cycles and frame period shall be 420000 cycles, with no jitter.
REQ-023 A frame-divider counter shall advance on each frame_start cycle while anim_en=1.
REQ-024 When the frame-divider reaches ANIM_DIV-1 and advances, it shall reset to 0 and anim_frame shall increment by 1, wrapping from 3 to 0.
REQ-025 With anim_en=0, the frame-divider and anim_frame shall hold; re-enabling shall resume from the held values.

Reset
REQ-026 Asserting reset_n low shall immediately clear the counters (DrawX=0, DrawY=0), clear the frame-divider and anim_frame, force frame_start=0, and fill the sync delay line with 1s (hs=1, vs=1).
REQ-027 blank shall read 1 during reset, since (0,0) is visible.
REQ-028 Reset asserted mid-frame shall abandon the frame; after release, counting restarts from (0,0) on the first rising edge.
REQ-029 Release of reset_n shall be synchronised externally; the block shall not add a reset synchroniser.

Structure
REQ-030 The package vga_timing_pkg shall hold the H/V visible, front-porch, sync and back-porch constants (640/16/96/48, 480/10/2/33), the totals (800, 525), and the counter widths.
REQ-031 One sub-module, sync_delay_line (parameter DEPTH, width 2, reset value 2'b11), shall implement the hs/vs delay.
REQ-032 Counters and delay stages shall use only vga_clk and reset_n; no derived clocks.

Verification
REQ-033 Reset check: hold reset_n low -> DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, anim_frame=0; release reset -> DrawX=1 after the first edge.
REQ-034 Horizontal check: over one line -> blank falls when DrawX=640; raw hs low from DrawX=656 to 751; hs output low for 96 cycles starting 2 cycles later (PIPE_DELAY=2); DrawY increments when DrawX goes 799->0.
REQ-035 Frame check: run 2 frames -> vs low for 1600 cycles per frame; frame_start pulses exactly once per frame, 420000 cycles apart; the first pulse occurs 420000 cycles after reset release.
REQ-036 Animation check: anim_en=1 for 33 frames -> anim_frame steps 0,1,2,3,0 every 8 frame_start pulses; drop anim_en for 5 frames -> anim_frame and the divider hold.
REQ-037 Mid-frame reset check: pulse reset_n low at DrawX=300, DrawY=200 -> outputs match REQ-026 immediately; the next frame_start occurs 420000 cycles after release.
REQ-038 PIPE_DELAY=0 build: hs and vs align with the raw decode on the same cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and types for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ANIM_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic in_window(cnt_t pos, cnt_t first, cnt_t last);
    return (pos >= first) && (pos <= last);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Shift register that delays the 2-bit {hs,vs} sync pair by DEPTH clocks; resets to idle-high.
module sync_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] raw,
  output logic [1:0] delayed
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign delayed = raw;
    end else begin : g_pipe
      logic [1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= 2'b11;
        end else begin
          stage[0] <= raw;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign delayed = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, visible-area decode, pipeline-aligned syncs, frame pulse and sprite animation index.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned H_VIS      = H_VISIBLE,
  parameter int unsigned H_FP       = H_FRONT,
  parameter int unsigned H_SW       = H_SYNC,
  parameter int unsigned H_BP       = H_BACK,
  parameter int unsigned V_VIS      = V_VISIBLE,
  parameter int unsigned V_FP       = V_FRONT,
  parameter int unsigned V_SW       = V_SYNC,
  parameter int unsigned V_BP       = V_BACK
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       anim_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [1:0] anim_frame
);

  localparam cnt_t H_LAST   = cnt_t'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
  localparam cnt_t HS_FIRST = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_VIS + H_FP + H_SW - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_VIS + V_FP + V_SW - 1);

  localparam int unsigned   DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  logic             h_last;
  logic             v_last;
  sync_t            sync_raw;
  sync_t            sync_out;
  logic [DIV_W-1:0] div;

  assign h_last = (DrawX == H_LAST);
  assign v_last = (DrawY == V_LAST);

  // frame_start is registered off the (last,last) position, so it lands on the
  // (0,0) cycle after a wrap but never on the (0,0) that follows reset.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= h_last ? '0 : DrawX + 1'b1;
      frame_start <= h_last && v_last;
      if (h_last) DrawY <= v_last ? '0 : DrawY + 1'b1;
    end
  end

  assign blank       = (DrawX < H_VIS_C) && (DrawY < V_VIS_C);
  assign sync_raw.hs = !in_window(DrawX, HS_FIRST, HS_LAST);
  assign sync_raw.vs = !in_window(DrawY, VS_FIRST, VS_LAST);

  sync_delay_line #(
    .DEPTH(PIPE_DELAY)
  ) u_sync_delay (
    .clk    (vga_clk),
    .rst_n  (reset_n),
    .raw    (sync_raw),
    .delayed(sync_out)
  );

  assign hs = sync_out.hs;
  assign vs = sync_out.vs;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      anim_frame <= '0;
    end else if (frame_start && anim_en) begin
      if (div == DIV_LAST) begin
        div        <= '0;
        anim_frame <= anim_frame + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size generator for line timing, reduced-geometry copies (PIPE_DELAY 2 and 0) for frame/animation behaviour.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
  } geo_t;

  localparam geo_t GB = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33};
  localparam geo_t GS = '{hv:16, hf:2, hs:4, hb:2, vv:10, vf:2, vs:2, vb:2};
  localparam int ADIV = 8;
  localparam int F_S  = 24 * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s, anim_en;
  logic [9:0] dx [3];
  logic [9:0] dy [3];
  logic       bl [3];
  logic       hsv [3];
  logic       vsv [3];
  logic       fsv [3];
  logic [1:0] af [3];

  int checks = 0;
  int failures = 0;

  vga_timing_gen #(.PIPE_DELAY(2), .ANIM_DIV(ADIV)) dut (
    .vga_clk(clk), .reset_n(rst_b), .anim_en(anim_en),
    .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]), .hs(hsv[0]), .vs(vsv[0]),
    .frame_start(fsv[0]), .anim_frame(af[0])
  );

  vga_timing_gen #(
    .PIPE_DELAY(2), .ANIM_DIV(ADIV),
    .H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(2),
    .V_VIS(10), .V_FP(2), .V_SW(2), .V_BP(2)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_s), .anim_en(anim_en),
    .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]), .hs(hsv[1]), .vs(vsv[1]),
    .frame_start(fsv[1]), .anim_frame(af[1])
  );

  vga_timing_gen #(
    .PIPE_DELAY(0), .ANIM_DIV(ADIV),
    .H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(2),
    .V_VIS(10), .V_FP(2), .V_SW(2), .V_BP(2)
  ) dut_z (
    .vga_clk(clk), .reset_n(rst_s), .anim_en(anim_en),
    .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]), .hs(hsv[2]), .vs(vsv[2]),
    .frame_start(fsv[2]), .anim_frame(af[2])
  );

  // Reference model: everything derives from elapsed cycles since reset release.
  function automatic int htot(geo_t g); return g.hv + g.hf + g.hs + g.hb; endfunction
  function automatic int vtot(geo_t g); return g.vv + g.vf + g.vs + g.vb; endfunction
  function automatic int exp_x(geo_t g, int t); return t % htot(g); endfunction
  function automatic int exp_y(geo_t g, int t); return (t / htot(g)) % vtot(g); endfunction
  function automatic logic exp_blank(geo_t g, int t);
    return (exp_x(g, t) < g.hv) && (exp_y(g, t) < g.vv);
  endfunction
  function automatic logic exp_hs(geo_t g, int t, int pd);
    int x;
    if (t < pd) return 1'b1;
    x = exp_x(g, t - pd);
    return !((x >= g.hv + g.hf) && (x < g.hv + g.hf + g.hs));
  endfunction
  function automatic logic exp_vs(geo_t g, int t, int pd);
    int y;
    if (t < pd) return 1'b1;
    y = exp_y(g, t - pd);
    return !((y >= g.vv + g.vf) && (y < g.vv + g.vf + g.vs));
  endfunction
  function automatic logic exp_fs(geo_t g, int t);
    return (t > 0) && (t % (htot(g) * vtot(g)) == 0);
  endfunction
  function automatic logic [1:0] exp_anim(int n); return 2'((n / ADIV) % 4); endfunction
  function automatic int pd_of(int k); return (k == 2) ? 0 : 2; endfunction

  int t_b, t_s, nen_s;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) t_b <= 0;
    else        t_b <= t_b + 1;
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      t_s   <= 0;
      nen_s <= 0;
    end else begin
      if (exp_fs(GS, t_s) && anim_en) nen_s <= nen_s + 1;
      t_s <= t_s + 1;
    end
  end

  task automatic test_reset();
    rst_b = 1'b0; rst_s = 1'b0; anim_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dx[k] !== 10'd0 || dy[k] !== 10'd0) begin
        failures++; $display("FAIL reset_xy[%0d] got=%0d,%0d exp=0,0", k, dx[k], dy[k]);
      end
      checks++; if (bl[k] !== 1'b1) begin
        failures++; $display("FAIL reset_blank[%0d] got=%b exp=1", k, bl[k]);
      end
      checks++; if (hsv[k] !== 1'b1 || vsv[k] !== 1'b1) begin
        failures++; $display("FAIL reset_sync[%0d] got=%b%b exp=11", k, hsv[k], vsv[k]);
      end
      checks++; if (fsv[k] !== 1'b0 || af[k] !== 2'd0) begin
        failures++; $display("FAIL reset_fs_anim[%0d] got=%b,%0d exp=0,0", k, fsv[k], af[k]);
      end
    end
    rst_b = 1'b1; rst_s = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dx[k] !== 10'd1) begin
        failures++; $display("FAIL release_x[%0d] got=%0d exp=1", k, dx[k]);
      end
    end
  endtask

  task automatic test_horizontal();
    int hs_low = 0;
    while (t_b < 1700) begin
      @(negedge clk);
      checks++; if (dx[0] !== 10'(exp_x(GB, t_b)) || dy[0] !== 10'(exp_y(GB, t_b))) begin
        failures++; $display("FAIL h_xy t=%0d got=%0d,%0d exp=%0d,%0d", t_b, dx[0], dy[0],
                             exp_x(GB, t_b), exp_y(GB, t_b));
      end
      checks++; if (bl[0] !== exp_blank(GB, t_b)) begin
        failures++; $display("FAIL h_blank t=%0d got=%b exp=%b", t_b, bl[0], exp_blank(GB, t_b));
      end
      checks++; if (hsv[0] !== exp_hs(GB, t_b, 2) || vsv[0] !== 1'b1) begin
        failures++; $display("FAIL h_sync t=%0d got=%b%b exp=%b1", t_b, hsv[0], vsv[0],
                             exp_hs(GB, t_b, 2));
      end
      if (t_b >= 800 && t_b < 1600 && hsv[0] === 1'b0) hs_low++;
    end
    checks++; if (hs_low != 96) begin
      failures++; $display("FAIL h_hs_width got=%0d exp=96", hs_low);
    end
  endtask

  task automatic test_frame();
    int fs_cnt [3];
    int fs_first [3];
    int vs_low [3];
    for (int k = 0; k < 3; k++) begin fs_cnt[k] = 0; fs_first[k] = -1; vs_low[k] = 0; end
    @(negedge clk) rst_s = 1'b0;
    @(negedge clk) rst_s = 1'b1;
    while (t_s <= 2 * F_S + 4) begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (dx[k] !== 10'(exp_x(GS, t_s)) || dy[k] !== 10'(exp_y(GS, t_s))) begin
          failures++; $display("FAIL f_xy[%0d] t=%0d got=%0d,%0d exp=%0d,%0d", k, t_s, dx[k], dy[k],
                               exp_x(GS, t_s), exp_y(GS, t_s));
        end
        checks++; if (hsv[k] !== exp_hs(GS, t_s, pd_of(k)) || vsv[k] !== exp_vs(GS, t_s, pd_of(k))) begin
          failures++; $display("FAIL f_sync[%0d] t=%0d got=%b%b exp=%b%b", k, t_s, hsv[k], vsv[k],
                               exp_hs(GS, t_s, pd_of(k)), exp_vs(GS, t_s, pd_of(k)));
        end
        checks++; if (fsv[k] !== exp_fs(GS, t_s) || bl[k] !== exp_blank(GS, t_s)) begin
          failures++; $display("FAIL f_fs_blank[%0d] t=%0d got=%b%b exp=%b%b", k, t_s, fsv[k], bl[k],
                               exp_fs(GS, t_s), exp_blank(GS, t_s));
        end
        if (fsv[k] === 1'b1) begin
          fs_cnt[k]++;
          if (fs_first[k] < 0) fs_first[k] = t_s;
        end
        if (vsv[k] === 1'b0 && t_s >= F_S && t_s < 2 * F_S) vs_low[k]++;
      end
      @(negedge clk);
    end
    for (int k = 1; k < 3; k++) begin
      checks++; if (fs_cnt[k] != 2 || fs_first[k] != F_S) begin
        failures++; $display("FAIL f_pulses[%0d] got=%0d@%0d exp=2@%0d", k, fs_cnt[k], fs_first[k], F_S);
      end
      checks++; if (vs_low[k] != GS.vs * htot(GS)) begin
        failures++; $display("FAIL f_vs_width[%0d] got=%0d exp=%0d", k, vs_low[k], GS.vs * htot(GS));
      end
    end
  endtask

  task automatic test_anim();
    logic [1:0] held;
    @(negedge clk) rst_s = 1'b0;
    @(negedge clk) begin rst_s = 1'b1; anim_en = 1'b1; end
    repeat (33 * F_S + 2) begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (af[k] !== exp_anim(nen_s)) begin
          failures++; $display("FAIL anim_run[%0d] t=%0d got=%0d exp=%0d", k, t_s, af[k], exp_anim(nen_s));
        end
      end
      @(negedge clk);
    end
    held = exp_anim(nen_s);
    anim_en = 1'b0;
    repeat (5 * F_S) begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (af[k] !== exp_anim(nen_s)) begin
          failures++; $display("FAIL anim_hold[%0d] t=%0d got=%0d exp=%0d", k, t_s, af[k], exp_anim(nen_s));
        end
      end
      @(negedge clk);
    end
    for (int k = 1; k < 3; k++) begin
      checks++; if (af[k] !== held) begin
        failures++; $display("FAIL anim_held[%0d] got=%0d exp=%0d", k, af[k], held);
      end
    end
    for (int f = 0; f < 10; f++) begin
      anim_en = 1'($urandom_range(0, 1));
      repeat (F_S) begin
        for (int k = 1; k < 3; k++) begin
          checks++; if (af[k] !== exp_anim(nen_s)) begin
            failures++; $display("FAIL anim_rand[%0d] t=%0d got=%0d exp=%0d", k, t_s, af[k], exp_anim(nen_s));
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int fs_first [3];
    @(negedge clk) rst_s = 1'b0;
    @(negedge clk) begin rst_s = 1'b1; anim_en = 1'b1; end
    repeat (9 * F_S + $urandom_range(60, F_S - 60)) @(negedge clk);
    #2 rst_s = 1'b0;
    #1;
    for (int k = 1; k < 3; k++) begin
      fs_first[k] = -1;
      checks++; if (dx[k] !== 10'd0 || dy[k] !== 10'd0 || bl[k] !== 1'b1) begin
        failures++; $display("FAIL mid_xy[%0d] got=%0d,%0d,%b exp=0,0,1", k, dx[k], dy[k], bl[k]);
      end
      checks++; if (hsv[k] !== 1'b1 || vsv[k] !== 1'b1 || fsv[k] !== 1'b0 || af[k] !== 2'd0) begin
        failures++; $display("FAIL mid_outs[%0d] got=%b%b%b,%0d exp=110,0", k, hsv[k], vsv[k], fsv[k], af[k]);
      end
    end
    @(negedge clk) rst_s = 1'b1;
    while (t_s <= F_S + 3) begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (dx[k] !== 10'(exp_x(GS, t_s)) || dy[k] !== 10'(exp_y(GS, t_s))) begin
          failures++; $display("FAIL mid_run[%0d] t=%0d got=%0d,%0d exp=%0d,%0d", k, t_s, dx[k], dy[k],
                               exp_x(GS, t_s), exp_y(GS, t_s));
        end
        if (fsv[k] === 1'b1 && fs_first[k] < 0) fs_first[k] = t_s;
      end
      @(negedge clk);
    end
    for (int k = 1; k < 3; k++) begin
      checks++; if (fs_first[k] != F_S) begin
        failures++; $display("FAIL mid_first_fs[%0d] got=%0d exp=%0d", k, fs_first[k], F_S);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_frame();
    test_anim();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
